deadlock_cycle_recorder: RTL and testbench

DEADLOCK_CYCLE_RECORDER -- requirements
Module: deadlock_cycle_recorder

---
 rtl/deadlock_rec_pkg.sv | 27 ++
 rtl/dl_rec_fifo.sv | 48 ++++
 rtl/deadlock_cycle_recorder.sv | 166 ++++++++++++++++
 tb/tb_deadlock_cycle_recorder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deadlock_rec_pkg.sv
// rtl/deadlock_rec_pkg.sv - shared record kinds, FSM encoding and width helpers
package deadlock_rec_pkg;

   // Record kinds carried in rec_data[REC_W-1 -: 2]
   localparam logic [1:0] KIND_START = 2'd0;
   localparam logic [1:0] KIND_HOP   = 2'd1;
   localparam logic [1:0] KIND_END   = 2'd2;
   localparam logic [1:0] KIND_TOTAL = 2'd3;

   // Recorder FSM encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_FILTER   = 3'd1;
   localparam logic [2:0] ST_DETECTED = 3'd2;
   localparam logic [2:0] ST_REPORT   = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // Bits needed to name one process; never less than one
   function automatic int idx_width(input int proc_num);
      return ($clog2(proc_num) < 1) ? 1 : $clog2(proc_num);
   endfunction

   // Record layout: {kind[1:0], cycle_id[7:0], value[IDX_W-1:0]}
   function automatic int rec_width(input int proc_num);
      return 2 + 8 + idx_width(proc_num);
   endfunction

endpackage

// File: rtl/dl_rec_fifo.sv
// rtl/dl_rec_fifo.sv - record FIFO, accepts a push into a full FIFO only alongside a pop
module dl_rec_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointer compare with a wrap bit tells full from empty
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      head    = mem[rd_ptr[AW-1:0]];
   end

   // Storage needs no reset: entries are only visible between the pointers
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Pointers advance on accepted push/pop; reset empties the FIFO at once
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/deadlock_cycle_recorder.sv
// rtl/deadlock_cycle_recorder.sv - deadlock filter, cycle walker and record emitter
module deadlock_cycle_recorder
   import deadlock_rec_pkg::*;
#(
   parameter int  PROC_NUM      = 4,
   parameter int  FIFO_DEPTH    = 16,
   parameter int  STABLE_CYCLES = 4,
   localparam int IDX_W         = idx_width(PROC_NUM),
   localparam int REC_W         = rec_width(PROC_NUM)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_in_vec,
   output logic                dl_detect_out,
   output logic [PROC_NUM-1:0] origin,
   output logic                token_clear,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [REC_W-1:0]    rec_data,
   output logic                overflow,
   output logic                done
);
   localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

   logic [2:0]          state;
   logic [PROC_NUM-1:0] filt_val;
   logic [PROC_NUM-1:0] detect_reg;
   logic [PROC_NUM-1:0] done_reg;
   logic [PROC_NUM-1:0] origin_reg;
   logic [PROC_NUM-1:0] prev_hop;
   logic [PROC_NUM-1:0] pending;
   logic [PROC_NUM-1:0] origin_hot;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_next;
   logic [7:0]          cycle_id;
   logic [IDX_W-1:0]    origin_idx;
   logic [IDX_W-1:0]    lo_idx;
   logic [IDX_W-1:0]    hi_idx;
   logic                hits_origin;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic [REC_W-1:0]    push_data;

   // Lowest not-yet-closed detected process opens the next cycle; a hop is named by its highest bit
   always_comb begin
      pending    = detect_reg & ~done_reg;
      origin_hot = pending & (~pending + 1'b1);
      lo_idx     = '0;
      hi_idx     = '0;
      for (int i = PROC_NUM - 1; i >= 0; i--) begin
         if (pending[i]) lo_idx = IDX_W'(i);
      end
      for (int i = 0; i < PROC_NUM; i++) begin
         if (dl_in_vec[i]) hi_idx = IDX_W'(i);
      end
   end

   // Observable outputs and the single record (if any) produced this cycle
   always_comb begin
      hits_origin   = (dl_in_vec & origin_reg) != '0;
      dl_detect_out = |detect_reg;
      origin        = (state == ST_DETECTED) ? origin_hot : '0;
      token_clear   = (state == ST_REPORT) && hits_origin;
      done          = (state == ST_DONE);
      count_next    = (state == ST_FILTER && dl_in_vec == filt_val) ? count + 1'b1 : CNT_W'(1);
      push          = 1'b0;
      push_data     = '0;
      case (state)
         ST_DETECTED: begin
            push = 1'b1;
            if (pending != '0) push_data = {KIND_START, cycle_id, lo_idx};
            else               push_data = {KIND_TOTAL, cycle_id - 8'd1, {IDX_W{1'b0}}};
         end
         ST_REPORT: begin
            if (hits_origin) begin
               push      = 1'b1;
               push_data = {KIND_END, cycle_id, origin_idx};
            end else if (dl_in_vec != '0 && dl_in_vec != prev_hop) begin
               push      = 1'b1;
               push_data = {KIND_HOP, cycle_id, hi_idx};
            end
         end
         default: ;
      endcase
   end

   // Recorder FSM: filter a stable blocked vector, then walk cycles until every detected process is closed
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         filt_val   <= '0;
         count      <= '0;
         detect_reg <= '0;
         done_reg   <= '0;
         origin_reg <= '0;
         origin_idx <= '0;
         prev_hop   <= '0;
         cycle_id   <= 8'd1;
      end else begin
         case (state)
            ST_IDLE, ST_FILTER: begin
               if (dl_in_vec == '0) begin
                  state <= ST_IDLE;
                  count <= '0;
               end else begin
                  filt_val <= dl_in_vec;
                  count    <= count_next;
                  if (count_next == CNT_TARGET) begin
                     state      <= ST_DETECTED;
                     detect_reg <= dl_in_vec;
                  end else begin
                     state <= ST_FILTER;
                  end
               end
            end
            ST_DETECTED: begin
               if (pending != '0) begin
                  origin_reg <= origin_hot;
                  origin_idx <= lo_idx;
                  prev_hop   <= origin_hot;
                  state      <= ST_REPORT;
               end else begin
                  state <= ST_DONE;
               end
            end
            ST_REPORT: begin
               if (hits_origin) begin
                  done_reg <= done_reg | (dl_in_vec & detect_reg) | origin_reg;
                  if (cycle_id != 8'hFF) cycle_id <= cycle_id + 8'd1;
                  state <= ST_DETECTED;
               end else if (dl_in_vec != '0 && dl_in_vec != prev_hop) begin
                  prev_hop <= dl_in_vec;
               end
            end
            default: state <= ST_DONE;
         endcase
      end
   end

   // A record that finds the FIFO full with no pop is lost; remember that
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                    overflow <= 1'b0;
      else if (push && full && !pop) overflow <= 1'b1;
   end

   assign rec_valid = !empty;
   assign pop       = rec_valid && rec_ready;

   dl_rec_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head      (rec_data)
   );

endmodule

// File: tb/tb_deadlock_cycle_recorder.sv
// tb/tb_deadlock_cycle_recorder.sv - randomized and directed bench against a behavioural recorder model
module tb_deadlock_cycle_recorder;
   localparam int PROC_NUM      = 4;
   localparam int FIFO_DEPTH    = 2;
   localparam int STABLE_CYCLES = 4;
   localparam int REC_W         = 12;

   logic                clock = 1'b0;
   logic                reset;
   logic [PROC_NUM-1:0] dl_in_vec;
   logic                dl_detect_out;
   logic [PROC_NUM-1:0] origin;
   logic                token_clear;
   logic                rec_valid;
   logic                rec_ready;
   logic [REC_W-1:0]    rec_data;
   logic                overflow;
   logic                done;

   int total = 0;
   int bad   = 0;

   deadlock_cycle_recorder #(
      .PROC_NUM      (PROC_NUM),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .dl_in_vec     (dl_in_vec),
      .dl_detect_out (dl_detect_out),
      .origin        (origin),
      .token_clear   (token_clear),
      .rec_valid     (rec_valid),
      .rec_ready     (rec_ready),
      .rec_data      (rec_data),
      .overflow      (overflow),
      .done          (done)
   );

   always #5 clock = ~clock;

   // Behavioural model state: searching for a stable run, choosing an origin, walking a cycle, finished
   logic [3:0]  m_run_val  = '0;
   int          m_run_len  = 0;
   logic [3:0]  m_detect   = '0;
   logic [3:0]  m_closed   = '0;
   logic [3:0]  m_last_hop = '0;
   bit          m_in_cycle = 0;
   bit          m_finished = 0;
   int          m_origin   = 0;
   int          m_cycle    = 1;
   int          m_ends     = 0;
   bit          m_ovf      = 0;
   logic [11:0] m_q[$];

   logic [11:0] got_q[$];
   int          tc_count = 0;

   function automatic logic [11:0] mk(input int kind, input int cyc, input int val);
      return {kind[1:0], cyc[7:0], val[1:0]};
   endfunction

   function automatic int low_idx(input logic [3:0] v);
      int x;
      x = int'(v);
      return $clog2(x & -x);
   endfunction

   function automatic int high_idx(input logic [3:0] v);
      return $clog2(int'(v) + 1) - 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset;
      m_run_val  = '0;
      m_run_len  = 0;
      m_detect   = '0;
      m_closed   = '0;
      m_last_hop = '0;
      m_in_cycle = 0;
      m_finished = 0;
      m_origin   = 0;
      m_cycle    = 1;
      m_ends     = 0;
      m_ovf      = 0;
      m_q.delete();
   endtask

   task automatic model_step(input logic [3:0] v, input logic r);
      logic [3:0]  pend;
      logic [11:0] rec;
      bit          has;
      bit          take;
      pend = m_detect & ~m_closed;
      has  = 0;
      rec  = '0;
      take = (m_q.size() != 0) && r;
      if (!m_finished) begin
         if (m_in_cycle) begin
            if (v[m_origin]) begin
               has        = 1;
               rec        = mk(2, m_cycle, m_origin);
               m_closed   = m_closed | (v & m_detect) | 4'(1 << m_origin);
               m_ends     = m_ends + 1;
               if (m_cycle < 255) m_cycle = m_cycle + 1;
               m_in_cycle = 0;
            end else if (v != 0 && v != m_last_hop) begin
               has        = 1;
               rec        = mk(1, m_cycle, high_idx(v));
               m_last_hop = v;
            end
         end else if (m_detect != 0) begin
            if (pend != 0) begin
               m_origin   = low_idx(pend);
               has        = 1;
               rec        = mk(0, m_cycle, m_origin);
               m_last_hop = 4'(1 << m_origin);
               m_in_cycle = 1;
            end else begin
               has        = 1;
               rec        = mk(3, m_ends, 0);
               m_finished = 1;
            end
         end else begin
            if (v == 0) begin
               m_run_len = 0;
            end else begin
               if (m_run_len > 0 && v == m_run_val) m_run_len = m_run_len + 1;
               else begin
                  m_run_val = v;
                  m_run_len = 1;
               end
               if (m_run_len >= STABLE_CYCLES) m_detect = v;
            end
         end
      end
      if (take) void'(m_q.pop_front());
      if (has) begin
         if (m_q.size() < FIFO_DEPTH) m_q.push_back(rec);
         else m_ovf = 1;
      end
   endtask

   always @(posedge clock or negedge reset) begin : model
      if (!reset) model_reset();
      else        model_step(dl_in_vec, rec_ready);
   end

   // Every cycle: DUT outputs against the model; also log accepted records and token_clear pulses
   always @(negedge clock) begin : compare
      logic [3:0] pend;
      logic [3:0] exp_origin;
      bit         choosing;
      choosing   = (m_detect != 0) && !m_in_cycle && !m_finished;
      pend       = m_detect & ~m_closed;
      exp_origin = (choosing && pend != 0) ? 4'(1 << low_idx(pend)) : 4'b0;
      chk("dl_detect_out", 32'(dl_detect_out), 32'(m_detect != 0));
      chk("origin", 32'(origin), 32'(exp_origin));
      chk("token_clear", 32'(token_clear), 32'(m_in_cycle && dl_in_vec[m_origin]));
      chk("rec_valid", 32'(rec_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rec_data", 32'(rec_data), 32'(m_q[0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("done", 32'(done), 32'(m_finished));
      if (reset && rec_valid && rec_ready) got_q.push_back(rec_data);
      if (reset && token_clear) tc_count++;
   end

   task automatic cyc(input logic [3:0] v, input logic r);
      dl_in_vec = v;
      rec_ready = r;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset     = 1'b0;
      dl_in_vec = '0;
      rec_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      got_q.delete();
      tc_count = 0;
   endtask

   task automatic check_log(input string name, input logic [11:0] exp[$]);
      chk({name, "_count"}, 32'(got_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         chk(name, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
      end
   endtask

   task automatic run_simple_cycle(input logic r_end);
      repeat (5) cyc(4'b0011, r_end);
      cyc(4'b0010, r_end);
      cyc(4'b0011, 1'b1);
      repeat (4) cyc(4'b0000, 1'b1);
   endtask

   initial begin
      logic [3:0] rv;
      int         hold;
      rv        = '0;
      hold      = 0;
      reset     = 1'b0;
      dl_in_vec = '0;
      rec_ready = 1'b0;
      @(posedge clock);
      #1;
      chk("rst_detect", 32'(dl_detect_out), 32'd0);
      chk("rst_rec_valid", 32'(rec_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b1;

      // Three stable samples are not enough
      repeat (3) cyc(4'b0011, 1'b1);
      repeat (3) cyc(4'b0000, 1'b1);
      chk("short_detect", 32'(dl_detect_out), 32'd0);
      chk("short_records", 32'(got_q.size()), 32'd0);

      // One cycle 0 -> 1 -> 0 closing both detected processes
      do_reset();
      run_simple_cycle(1'b1);
      check_log("simple_log", '{12'h004, 12'h405, 12'h804, 12'hC04});
      chk("simple_tc", 32'(tc_count), 32'd1);
      chk("simple_done", 32'(done), 32'd1);
      chk("simple_ovf", 32'(overflow), 32'd0);

      // Two disjoint cycles out of 0101
      do_reset();
      repeat (5) cyc(4'b0101, 1'b1);
      cyc(4'b0001, 1'b1);
      cyc(4'b0000, 1'b1);
      cyc(4'b0100, 1'b1);
      repeat (4) cyc(4'b0000, 1'b1);
      check_log("two_log", '{12'h004, 12'h804, 12'h00A, 12'h80A, 12'hC08});
      chk("two_tc", 32'(tc_count), 32'd2);

      // Consumer stalled through the whole report
      do_reset();
      repeat (5) cyc(4'b0011, 1'b0);
      cyc(4'b0010, 1'b0);
      cyc(4'b0011, 1'b0);
      repeat (3) cyc(4'b0000, 1'b0);
      chk("stall_ovf", 32'(overflow), 32'd1);
      chk("stall_done", 32'(done), 32'd1);
      repeat (4) cyc(4'b0000, 1'b1);
      check_log("stall_log", '{12'h004, 12'h405});

      // Full FIFO drained in the same cycle as a push
      do_reset();
      repeat (5) cyc(4'b0011, 1'b0);
      cyc(4'b0010, 1'b0);
      cyc(4'b0011, 1'b1);
      repeat (4) cyc(4'b0000, 1'b1);
      chk("fullpop_ovf", 32'(overflow), 32'd0);
      check_log("fullpop_log", '{12'h004, 12'h405, 12'h804, 12'hC04});

      // Reset in the middle of a report
      do_reset();
      repeat (5) cyc(4'b0011, 1'b0);
      cyc(4'b0010, 1'b0);
      reset = 1'b0;
      #1;
      chk("midrst_rec_valid", 32'(rec_valid), 32'd0);
      chk("midrst_detect", 32'(dl_detect_out), 32'd0);
      chk("midrst_origin", 32'(origin), 32'd0);
      chk("midrst_token", 32'(token_clear), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      got_q.delete();
      tc_count = 0;
      run_simple_cycle(1'b1);
      check_log("redetect_log", '{12'h004, 12'h405, 12'h804, 12'hC04});

      // Random held vectors, random back-pressure, occasional reset
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            rv   = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 6);
         end
         hold--;
         reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         cyc(rv, 1'($urandom_range(0, 3) != 0));
      end
      reset = 1'b1;
      repeat (2) cyc(4'b0000, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
